// File: rtl/net_msg_to_mem_resp_queue.sv
// ---------------------------------------------------------------------------
// net_msg_to_mem_resp_queue
//
// Core-side receive stage that sits right after the bank-side
// memory-response-to-network adapter. It accepts split control/data network
// response messages and drops any message addressed to another core. It
// applies the security-domain check and unpacks the result into a memory
// response. That response is buffered in a 2-entry FIFO whose head drives
// the core's response port directly from registers.
//
// Ports:
//   clk               clock
//   reset             asynchronous, active-low reset
//   mode              1 = domain enforcement enabled
//   domain            current security domain of the attached core
//   net_val/net_rdy   network response handshake
//   net_msg_control   {dest, src, opaque, pkt_domain, fail, mem_ctrl}
//   net_msg_data      response data
//   resp_val/resp_rdy memory response handshake
//   resp_msg_control  {type, opaque, len}
//   resp_msg_data     response data (zeroed when blocked)
//   resp_fail         response failed or was blocked by the domain check
//   misroute_cnt      saturating count of dropped misrouted messages
//   violation_cnt     saturating count of domain-blocked messages
// ---------------------------------------------------------------------------
module net_msg_to_mem_resp_queue #(
    parameter int p_core_id           = 0,
    parameter int p_mem_opaque_nbits  = 8,
    parameter int p_mem_data_nbits    = 32,
    parameter int p_net_opaque_nbits  = 4,
    parameter int p_net_srcdest_nbits = 3,
    parameter int c_mem_cnbits        = 3 + p_mem_opaque_nbits + 2,
    parameter int c_net_cnbits        = 2 * p_net_srcdest_nbits + p_net_opaque_nbits
                                        + c_mem_cnbits + 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        mode,
    input  logic                        domain,
    input  logic                        net_val,
    output logic                        net_rdy,
    input  logic [c_net_cnbits-1:0]     net_msg_control,
    input  logic [p_mem_data_nbits-1:0] net_msg_data,
    output logic                        resp_val,
    input  logic                        resp_rdy,
    output logic [c_mem_cnbits-1:0]     resp_msg_control,
    output logic [p_mem_data_nbits-1:0] resp_msg_data,
    output logic                        resp_fail,
    output logic [7:0]                  misroute_cnt,
    output logic [7:0]                  violation_cnt
);

    localparam int ns = p_net_srcdest_nbits;
    localparam int no = p_net_opaque_nbits;
    localparam logic [ns-1:0] c_core_dest = ns'(p_core_id);

    // Header fields. The network src and opaque are not needed past this stage.
    logic [ns-1:0]               dest;
    logic [ns-1:0]               unused_src;
    logic [no-1:0]               unused_net_opaque;
    logic                        pkt_domain;
    logic                        pkt_fail;
    logic [c_mem_cnbits-1:0]     mem_ctrl;

    assign dest              = net_msg_control[c_net_cnbits-1 -: ns];
    assign unused_src        = net_msg_control[c_net_cnbits-1-ns -: ns];
    assign unused_net_opaque = net_msg_control[c_mem_cnbits+2 +: no];
    assign pkt_domain        = net_msg_control[c_mem_cnbits+1];
    assign pkt_fail          = net_msg_control[c_mem_cnbits];
    assign mem_ctrl          = net_msg_control[c_mem_cnbits-1:0];

    // Queue storage. The head entry registers are the response outputs.
    logic [1:0]                  count;
    logic [c_mem_cnbits-1:0]     tail_ctrl;
    logic [p_mem_data_nbits-1:0] tail_data;
    logic                        tail_fail;

    logic                        full;
    logic                        accept;
    logic                        dequeue;
    logic                        misroute;
    logic                        violation;
    logic                        enqueue;
    logic [p_mem_data_nbits-1:0] in_data;
    logic                        in_fail;

    assign full     = (count == 2'd2);
    assign resp_val = (count != 2'd0);
    assign dequeue  = resp_val && resp_rdy;
    // A full queue can still take a message in the cycle its head leaves.
    assign net_rdy  = !full || dequeue;
    assign accept   = net_val && net_rdy;

    // Classify the incoming message and form the entry that would be enqueued.
    // A misrouted message is dropped, so it is never also counted as a violation.
    always_comb begin
        misroute  = 1'b0;
        violation = 1'b0;
        enqueue   = 1'b0;
        in_data   = net_msg_data;
        in_fail   = pkt_fail;
        if (dest != c_core_dest) begin
            misroute = 1'b1;
        end else begin
            enqueue = accept;
            if (mode && (pkt_domain != domain)) begin
                violation = 1'b1;
                in_data   = '0;
                in_fail   = 1'b1;
            end
        end
    end

    // FIFO update. A new entry goes straight to the head when the head slot is
    // empty or is being vacated with nothing behind it; otherwise it goes to the
    // tail. When the queue is full and draining, the tail shifts into the head.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count            <= 2'd0;
            resp_msg_control <= '0;
            resp_msg_data    <= '0;
            resp_fail        <= 1'b0;
            tail_ctrl        <= '0;
            tail_data        <= '0;
            tail_fail        <= 1'b0;
        end else begin
            if (dequeue && full) begin
                resp_msg_control <= tail_ctrl;
                resp_msg_data    <= tail_data;
                resp_fail        <= tail_fail;
            end
            if (enqueue) begin
                if ((count == 2'd0) || ((count == 2'd1) && dequeue)) begin
                    resp_msg_control <= mem_ctrl;
                    resp_msg_data    <= in_data;
                    resp_fail        <= in_fail;
                end else begin
                    tail_ctrl <= mem_ctrl;
                    tail_data <= in_data;
                    tail_fail <= in_fail;
                end
            end
            case ({enqueue, dequeue})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Saturating event counters, updated only on the edge a message is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misroute_cnt  <= 8'd0;
            violation_cnt <= 8'd0;
        end else if (accept) begin
            if (misroute && (misroute_cnt != 8'hFF)) begin
                misroute_cnt <= misroute_cnt + 8'd1;
            end
            if (violation && (violation_cnt != 8'hFF)) begin
                violation_cnt <= violation_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_net_msg_to_mem_resp_queue.sv
// ---------------------------------------------------------------------------
// tb_net_msg_to_mem_resp_queue
//
// Directed testbench for net_msg_to_mem_resp_queue with default parameters
// (core id 0, 13-bit memory control, 25-bit network control, 32-bit data).
// Inputs are driven and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_net_msg_to_mem_resp_queue;

    logic        clk;
    logic        reset;
    logic        mode;
    logic        domain;
    logic        net_val;
    logic        net_rdy;
    logic [24:0] net_msg_control;
    logic [31:0] net_msg_data;
    logic        resp_val;
    logic        resp_rdy;
    logic [12:0] resp_msg_control;
    logic [31:0] resp_msg_data;
    logic        resp_fail;
    logic [7:0]  misroute_cnt;
    logic [7:0]  violation_cnt;

    int errors = 0;
    int checks = 0;

    net_msg_to_mem_resp_queue dut (
        .clk              (clk),
        .reset            (reset),
        .mode             (mode),
        .domain           (domain),
        .net_val          (net_val),
        .net_rdy          (net_rdy),
        .net_msg_control  (net_msg_control),
        .net_msg_data     (net_msg_data),
        .resp_val         (resp_val),
        .resp_rdy         (resp_rdy),
        .resp_msg_control (resp_msg_control),
        .resp_msg_data    (resp_msg_data),
        .resp_fail        (resp_fail),
        .misroute_cnt     (misroute_cnt),
        .violation_cnt    (violation_cnt)
    );

    // 10 ns clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds a network control word: {dest, src, opaque, pkt_domain, fail, mem_ctrl}.
    // src and opaque are filled with nonzero junk that must never leak out.
    function automatic logic [24:0] makeCtrl(input logic [2:0] dest, input logic pkt_domain,
                                             input logic fail, input logic [12:0] mem_ctrl);
        return {dest, 3'b101, 4'hA, pkt_domain, fail, mem_ctrl};
    endfunction

    // Compares one observed value against its expected value and counts it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives the network-side inputs.
    task automatic applyStimulus(input logic valid, input logic [24:0] ctrl,
                                 input logic [31:0] data);
        net_val         = valid;
        net_msg_control = ctrl;
        net_msg_data    = data;
    endtask

    // Advances to 1 ns past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        mode     = 1'b0;
        domain   = 1'b0;
        resp_rdy = 1'b1;
        applyStimulus(1'b0, '0, '0);

        // Reset state, sampled while reset is still asserted
        tick();
        tick();
        checkOutput("reset_resp_val", 32'(resp_val), 32'd0);
        checkOutput("reset_net_rdy", 32'(net_rdy), 32'd1);
        checkOutput("reset_misroute", 32'(misroute_cnt), 32'd0);
        checkOutput("reset_violation", 32'(violation_cnt), 32'd0);
        checkOutput("reset_ctrl", 32'(resp_msg_control), 32'd0);
        checkOutput("reset_data", resp_msg_data, 32'd0);
        checkOutput("reset_fail", 32'(resp_fail), 32'd0);
        reset = 1'b1;
        tick();

        // Plain delivery: type=0 opaque=0x05 len=0, so mem_ctrl = 0x014
        applyStimulus(1'b1, makeCtrl(3'd0, 1'b0, 1'b0, 13'h014), 32'hDEADBEEF);
        tick();
        applyStimulus(1'b0, '0, '0);
        checkOutput("basic_val", 32'(resp_val), 32'd1);
        checkOutput("basic_ctrl", 32'(resp_msg_control), 32'h014);
        checkOutput("basic_data", resp_msg_data, 32'hDEADBEEF);
        checkOutput("basic_fail", 32'(resp_fail), 32'd0);
        tick();
        checkOutput("basic_drained", 32'(resp_val), 32'd0);

        // Misrouted message is dropped and counted
        applyStimulus(1'b1, makeCtrl(3'd3, 1'b0, 1'b0, 13'h014), 32'hCAFEF00D);
        tick();
        applyStimulus(1'b0, '0, '0);
        checkOutput("misroute_val", 32'(resp_val), 32'd0);
        checkOutput("misroute_cnt1", 32'(misroute_cnt), 32'd1);
        tick();
        checkOutput("misroute_still_empty", 32'(resp_val), 32'd0);

        // Domain violation with enforcement on
        mode   = 1'b1;
        domain = 1'b0;
        applyStimulus(1'b1, makeCtrl(3'd0, 1'b1, 1'b0, 13'h0A5A), 32'h12345678);
        tick();
        applyStimulus(1'b0, '0, '0);
        checkOutput("viol_val", 32'(resp_val), 32'd1);
        checkOutput("viol_ctrl", 32'(resp_msg_control), 32'h0A5A);
        checkOutput("viol_data", resp_msg_data, 32'd0);
        checkOutput("viol_fail", 32'(resp_fail), 32'd1);
        checkOutput("viol_cnt1", 32'(violation_cnt), 32'd1);
        tick();

        // Same message with enforcement off passes unchanged
        mode = 1'b0;
        applyStimulus(1'b1, makeCtrl(3'd0, 1'b1, 1'b0, 13'h0A5A), 32'h12345678);
        tick();
        applyStimulus(1'b0, '0, '0);
        checkOutput("nomode_data", resp_msg_data, 32'h12345678);
        checkOutput("nomode_fail", 32'(resp_fail), 32'd0);
        checkOutput("nomode_viol_cnt", 32'(violation_cnt), 32'd1);
        tick();

        // Matching domain with enforcement on; upstream fail bit passes through
        mode   = 1'b1;
        domain = 1'b1;
        applyStimulus(1'b1, makeCtrl(3'd0, 1'b1, 1'b1, 13'h1F03), 32'h0BADF00D);
        tick();
        applyStimulus(1'b0, '0, '0);
        checkOutput("match_data", resp_msg_data, 32'h0BADF00D);
        checkOutput("match_fail", 32'(resp_fail), 32'd1);
        checkOutput("match_ctrl", 32'(resp_msg_control), 32'h1F03);
        checkOutput("match_viol_cnt", 32'(violation_cnt), 32'd1);
        tick();
        mode   = 1'b0;
        domain = 1'b0;

        // Backpressure: three back-to-back messages with resp_rdy low
        resp_rdy = 1'b0;
        applyStimulus(1'b1, makeCtrl(3'd0, 1'b0, 1'b0, 13'h0001), 32'h00000111);
        tick();
        checkOutput("bp_rdy_after1", 32'(net_rdy), 32'd1);
        applyStimulus(1'b1, makeCtrl(3'd0, 1'b0, 1'b0, 13'h0002), 32'h00000222);
        tick();
        checkOutput("bp_rdy_after2", 32'(net_rdy), 32'd0);
        applyStimulus(1'b1, makeCtrl(3'd0, 1'b0, 1'b0, 13'h0003), 32'h00000333);
        tick();
        checkOutput("bp_rdy_held", 32'(net_rdy), 32'd0);
        checkOutput("bp_head_a", resp_msg_data, 32'h00000111);
        resp_rdy = 1'b1;
        #1;
        checkOutput("bp_rdy_on_deq", 32'(net_rdy), 32'd1);
        tick();
        applyStimulus(1'b0, '0, '0);
        checkOutput("bp_head_b_val", 32'(resp_val), 32'd1);
        checkOutput("bp_head_b", resp_msg_data, 32'h00000222);
        checkOutput("bp_head_b_ctrl", 32'(resp_msg_control), 32'h0002);
        tick();
        checkOutput("bp_head_c_val", 32'(resp_val), 32'd1);
        checkOutput("bp_head_c", resp_msg_data, 32'h00000333);
        checkOutput("bp_head_c_ctrl", 32'(resp_msg_control), 32'h0003);
        tick();
        checkOutput("bp_drained", 32'(resp_val), 32'd0);

        // Misroute counter saturation: 300 more misrouted messages on top of 1
        applyStimulus(1'b1, makeCtrl(3'd5, 1'b0, 1'b0, 13'h0000), 32'h0);
        for (int i = 0; i < 253; i++) tick();
        checkOutput("sat_254", 32'(misroute_cnt), 32'd254);
        for (int i = 0; i < 47; i++) tick();
        applyStimulus(1'b0, '0, '0);
        checkOutput("sat_255", 32'(misroute_cnt), 32'd255);
        checkOutput("sat_no_resp", 32'(resp_val), 32'd0);

        // Reset with two entries queued
        resp_rdy = 1'b0;
        applyStimulus(1'b1, makeCtrl(3'd0, 1'b0, 1'b0, 13'h0011), 32'hAAAA0001);
        tick();
        applyStimulus(1'b1, makeCtrl(3'd0, 1'b0, 1'b0, 13'h0012), 32'hAAAA0002);
        tick();
        applyStimulus(1'b0, '0, '0);
        checkOutput("rst_pre_val", 32'(resp_val), 32'd1);
        checkOutput("rst_pre_full", 32'(net_rdy), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("rst_val", 32'(resp_val), 32'd0);
        checkOutput("rst_net_rdy", 32'(net_rdy), 32'd1);
        checkOutput("rst_misroute", 32'(misroute_cnt), 32'd0);
        checkOutput("rst_violation", 32'(violation_cnt), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        checkOutput("rst_stays_empty", 32'(resp_val), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/net_msg_to_mem_resp_queue.md
Name: net_msg_to_mem_resp_queue

Overview:
- Core-side receive stage directly downstream of the bank-side memory-response-to-network adapter.
- Accepts split control/data network response messages from the response network via val/rdy.
- Unpacks them back into memory response messages and buffers them in a 2-entry queue.
- Enforces the security-domain check on delivery to the core's memory response port, and counts misrouted and domain-violating messages.

Parameters:
- p_core_id, 0, network index of the core this stage serves.
- p_mem_opaque_nbits, 8, memory opaque width (mo).
- p_mem_data_nbits, 32, memory data width (md).
- p_net_opaque_nbits, 4, network opaque width (no).
- p_net_srcdest_nbits, 3, network src/dest width (ns).
- c_mem_cnbits, 3+mo+2, memory response control width: type, opaque, len.
- c_net_cnbits, 2*ns+no+c_mem_cnbits+2, network control message width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- mode  in  1  1 = domain enforcement enabled.
- domain  in  1  current domain of the attached core.
- net_val  in  1  network message valid.
- net_rdy  out  1  network message ready.
- net_msg_control  in  c_net_cnbits  {dest, src, opaque, {pkt_domain, fail, mem_ctrl}}, MSB first.
- net_msg_data  in  md  response data.
- resp_val  out  1  memory response valid.
- resp_rdy  in  1  memory response ready.
- resp_msg_control  out  c_mem_cnbits  {type, opaque, len}.
- resp_msg_data  out  md  response data.
- resp_fail  out  1  response failed or was blocked.
- misroute_cnt  out  8  saturating count of dropped misrouted messages.
- violation_cnt  out  8  saturating count of domain-blocked messages.

Behaviour:
- Reset (reset=0, asynchronous): queue empty, resp_val=0, net_rdy=1, both counters 0. resp_msg_control, resp_msg_data and resp_fail reset to 0.
- Asserting reset mid-transfer discards all queued entries immediately.
- Accept rule: a network message is accepted on a rising edge when net_val && net_rdy.
- net_rdy = !full || (resp_val && resp_rdy). A message may enter a full queue in the same cycle one leaves.
- Misroute: accepted message with dest != p_core_id[ns-1:0] is dropped, not enqueued; misroute_cnt increments, saturating at 255.
- Domain violation: when mode=1 and pkt_domain != domain (sampled at accept), the entry is enqueued with data forced to 0 and fail=1; violation_cnt increments, saturating at 255.
- Otherwise the entry is enqueued with mem_ctrl, data and fail unchanged. mode=0 disables the check.
- Queue: 2-entry FIFO with registered outputs; head drives the resp_* outputs.
- Latency: 1 cycle from accept to resp_val when empty; no combinational bypass.
- Dequeue on resp_val && resp_rdy.
- Simultaneous enqueue and dequeue when full: count stays 2 and order is preserved.
- Simultaneous enqueue and dequeue with 1 entry: the new entry becomes head next cycle.
- Empty: resp_val=0; resp_* hold their last value (don't care).
- Full with no dequeue: net_rdy=0 and upstream holds.
- A misrouted message arriving while full with no dequeue is not accepted, because net_rdy=0, and is not counted.
- Counters: registered; update on the accept edge only. A message is never counted twice.
- opaque and src fields of the network header are discarded. The memory opaque passes unchanged; its top ns bits carry the core id.

Test Plan:
- Reset, then with mode=0 send one message: dest=p_core_id=0, mem_ctrl type=0 opaque=0x05 len=0, data=0xDEADBEEF. Required: resp_val=1 the next cycle with identical control and data, resp_fail=0.
- Send dest=3 with p_core_id=0. Required: message accepted and dropped, resp_val stays 0, misroute_cnt=1.
- mode=1, domain=0, send pkt_domain=1 with data=0x12345678. Required: response data=0, resp_fail=1, violation_cnt=1. Repeat with mode=0. Required: data=0x12345678, resp_fail=0.
- Hold resp_rdy=0 and send 3 back-to-back messages. Required: net_rdy=0 after 2 accepts. Raise resp_rdy. Required: all 3 delivered in order, and the third accepted the same cycle the first dequeues.
- Send 300 misrouted messages. Required: misroute_cnt saturates at 255.
- Assert reset with 2 entries queued. Required: resp_val drops immediately and counters read 0.
